mem_arbiter: RTL and testbench

- Shares one interleaved_memory instance between NUM_REQ requesters, for example instruction fetch and load/store.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one access in flight at a time.
- Sits between requester logic and the memory. Drives every memory input except clock and reset.

---
 rtl/mem_cfg_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr.sv | 24 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_cfg_pkg.sv
// Shared memory-configuration types: access width, arbiter state set and the
// request bundle used between requesters and the interleaved memory.
package mem_cfg_pkg;

    localparam int unsigned MEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        mem_width_t            width;
        logic                  sext;
        logic [31:0]           wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundle of the memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_arbiter_if import mem_cfg_pkg::*; #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 10
);
    logic       [NUM_REQ-1:0]             req_valid_i;
    logic       [NUM_REQ-1:0]             req_ready_o;
    logic       [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
    logic       [NUM_REQ-1:0]             req_we_i;
    mem_width_t [NUM_REQ-1:0]             req_width_i;
    logic       [NUM_REQ-1:0]             req_sext_i;
    logic       [NUM_REQ-1:0][31:0]       req_wdata_i;
    logic       [NUM_REQ-1:0]             rsp_valid_o;
    logic       [NUM_REQ-1:0]             rsp_ready_i;
    logic       [31:0]                    rsp_rdata_o;
    logic       [ADDR_W-1:0]              mem_addr_o;
    logic                                 mem_we_o;
    mem_width_t                           mem_width_o;
    logic                                 mem_sext_o;
    logic       [31:0]                    mem_wdata_o;
    logic       [31:0]                    mem_rdata_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_width_i, req_sext_i,
               req_wdata_i, rsp_ready_i, mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_we_o,
               mem_width_o, mem_sext_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_width_i, req_sext_i,
               req_wdata_i, rsp_ready_i, mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, mem_addr_o, mem_we_o,
               mem_width_o, mem_sext_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational rotate-priority arbiter: the first valid index above
// last_grant (wrapping) receives a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);
    int unsigned idx;

    always_comb begin
        grant = '0;
        idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(last_grant) + off) % NUM_REQ;
            if (valid[IDX_W'(idx)] && (grant == '0)) begin
                grant[IDX_W'(idx)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between NUM_REQ requesters,
// one access in flight: IDLE -> ISSUE -> CAPTURE -> RESP.
module mem_arbiter import mem_cfg_pkg::*; #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 10
) (
    input logic          clk_i,
    input logic          rst_ni,
    mem_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ISSUE   = ISSUE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_RESP    = RESP;

    logic [1:0]         state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               accept;
    logic               cmd_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    mem_width_t         mem_width;
    logic               mem_sext;
    logic [31:0]        mem_wdata;
    logic [31:0]        rsp_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid      (bus.req_valid_i),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign ready  = (state == ST_IDLE) ? grant : '0;
    assign accept = |(bus.req_valid_i & ready);

    // mem_we is a register so that it drops with rst_ni, not at the next edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            cmd_we     <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_width  <= BYTE;
            mem_sext   <= 1'b0;
            mem_wdata  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mem_addr   <= bus.req_addr_i[grant_idx];
                        mem_we     <= bus.req_we_i[grant_idx];
                        cmd_we     <= bus.req_we_i[grant_idx];
                        mem_width  <= bus.req_width_i[grant_idx];
                        mem_sext   <= bus.req_sext_i[grant_idx];
                        mem_wdata  <= bus.req_wdata_i[grant_idx];
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_we <= 1'b0;
                    state  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_rdata        <= cmd_we ? '0 : bus.mem_rdata_i;
                    rsp_valid[owner] <= 1'b1;
                    state            <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i[owner]) begin
                        rsp_valid <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_width_o = mem_width;
    assign bus.mem_sext_o  = mem_sext;
    assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// scored against a transaction-level model with a shadow byte memory.
module tb_mem_arbiter;
    import mem_cfg_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 10;
    localparam int unsigned MSZ  = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW)) bus ();

    mem_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Memory stand-in: registered read one cycle after the address, write on the we edge.
    logic [7:0] mem     [MSZ];
    logic [7:0] ref_mem [MSZ];

    always @(posedge clk) begin
        logic [31:0] r;
        int          nb;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mem[bus.mem_addr_o + AW'(i)];
        case (bus.mem_width_o)
            BYTE:    r = {{24{bus.mem_sext_o & r[7]}}, r[7:0]};
            HALF:    r = {{16{bus.mem_sext_o & r[15]}}, r[15:0]};
            default: ;
        endcase
        bus.mem_rdata_i <= r;
        if (bus.mem_we_o) begin
            nb = (bus.mem_width_o == BYTE) ? 1 : (bus.mem_width_o == HALF) ? 2 : 4;
            for (int i = 0; i < nb; i++) mem[bus.mem_addr_o + AW'(i)] <= bus.mem_wdata_o[8*i +: 8];
        end
    end

    function automatic int nbytes(input mem_width_t w);
        return (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input mem_width_t w, input logic s);
        logic [31:0] v;
        int          n;
        v = '0;
        n = nbytes(w);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + AW'(i)];
        if (s && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        return v;
    endfunction

    // Transaction-level reference: accept at cycle c, memory command visible from
    // c+1 (we only at c+1), response from c+3 held until the owner takes it.
    int               cyc = 0;
    bit               busy = 0;
    int               owner = 0;
    int               acc_cyc = 0;
    int               last = NREQ - 1;
    logic [AW-1:0]    c_addr;
    logic             c_we;
    mem_width_t       c_width;
    logic             c_sext;
    logic [31:0]      c_wdata;
    logic [31:0]      exp_data;
    logic [NREQ-1:0]  acc_vec = '0;
    int               grant_log[$];
    int               we_cnt = 0;
    logic [AW-1:0]    we_addr = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int k;
        cyc++;
        if (!rst_n) begin
            busy    = 0;
            last    = NREQ - 1;
            acc_vec = '0;
        end else begin
            if (bus.mem_we_o) begin
                we_cnt++;
                we_addr = bus.mem_addr_o;
            end
            if (!busy) begin
                exp_rdy = '0;
                for (int s = 1; s <= NREQ; s++) begin
                    int j;
                    j = (last + s) % NREQ;
                    if (bus.req_valid_i[j] && exp_rdy == '0) exp_rdy[j] = 1'b1;
                end
                check("ready_idle", 32'(bus.req_ready_o), 32'(exp_rdy));
                check("rsp_valid_idle", 32'(bus.rsp_valid_o), 32'd0);
                check("we_idle", 32'(bus.mem_we_o), 32'd0);
                acc_vec = exp_rdy;
                if (exp_rdy != '0) begin
                    for (int j = 0; j < NREQ; j++) if (exp_rdy[j]) owner = j;
                    busy    = 1;
                    acc_cyc = cyc;
                    last    = owner;
                    c_addr  = bus.req_addr_i[owner];
                    c_we    = bus.req_we_i[owner];
                    c_width = bus.req_width_i[owner];
                    c_sext  = bus.req_sext_i[owner];
                    c_wdata = bus.req_wdata_i[owner];
                    exp_data = c_we ? 32'd0 : ref_read(c_addr, c_width, c_sext);
                    grant_log.push_back(owner);
                end
            end else begin
                acc_vec = '0;
                k = cyc - acc_cyc;
                check("ready_busy", 32'(bus.req_ready_o), 32'd0);
                check("mem_addr", 32'(bus.mem_addr_o), 32'(c_addr));
                check("mem_width", 32'(bus.mem_width_o), 32'(c_width));
                check("mem_sext", 32'(bus.mem_sext_o), 32'(c_sext));
                check("mem_wdata", bus.mem_wdata_o, c_wdata);
                check("mem_we", 32'(bus.mem_we_o), 32'((k == 1) && c_we));
                if (k == 2) begin
                    check("rsp_early", 32'(bus.rsp_valid_o), 32'd0);
                    if (c_we)
                        for (int i = 0; i < nbytes(c_width); i++) ref_mem[c_addr + AW'(i)] = c_wdata[8*i +: 8];
                end
                if (k >= 3) begin
                    check("rsp_valid", 32'(bus.rsp_valid_o), 32'(1) << owner);
                    check("rsp_rdata", bus.rsp_rdata_o, exp_data);
                    if (bus.rsp_ready_i[owner]) busy = 0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic we,
                           input mem_width_t w, input logic s, input logic [31:0] d);
        bus.req_valid_i[i] = 1'b1;
        bus.req_addr_i[i]  = a;
        bus.req_we_i[i]    = we;
        bus.req_width_i[i] = w;
        bus.req_sext_i[i]  = s;
        bus.req_wdata_i[i] = d;
    endtask

    // Returns one time unit after the accept edge, i.e. inside the ISSUE cycle.
    task automatic wait_accept(input int i, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (bus.req_valid_i[i] && bus.req_ready_o[i]) ok = 1;
            else waited++;
        end
        check($sformatf("accept_timeout%0d", i), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output logic [31:0] d);
        bit ok;
        ok = 0;
        d  = '0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (bus.rsp_valid_o[i]) begin
                ok = 1;
                d  = bus.rsp_rdata_o;
            end
        end
        check($sformatf("rsp_timeout%0d", i), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic poke_word(input logic [AW-1:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            mem[a + AW'(i)]     = v[8*i +: 8];
            ref_mem[a + AW'(i)] = v[8*i +: 8];
        end
    endtask

    initial begin
        logic [31:0] d;
        int          w;
        int          base;
        int          we0;
        bit          ok;

        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_we_i    = '0;
        bus.req_sext_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = '1;
        for (int i = 0; i < NREQ; i++) bus.req_width_i[i] = BYTE;
        for (int i = 0; i < MSZ; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        poke_word(10'h004, 32'h0DEFACED);
        poke_word(10'h010, 32'h00000080);
        poke_word(10'h020, 32'h11223344);

        // Reset values
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        check("rst_mem_width", 32'(bus.mem_width_o), 32'(BYTE));
        check("rst_mem_sext", 32'(bus.mem_sext_o), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention: both valid for six accesses
        base = grant_log.size();
        set_req(0, 10'h040, 1'b0, WORD, 1'b0, 32'd0);
        set_req(1, 10'h080, 1'b0, WORD, 1'b0, 32'd0);
        ok = 0;
        for (int t = 0; t < 80 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (grant_log.size() >= base + 6) ok = 1;
        end
        check("contention_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 bus.req_valid_i = '0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++)
            if (base + i < grant_log.size())
                check($sformatf("grant_order%0d", i), 32'(grant_log[base+i]), 32'(i % 2));

        // Single read
        we0 = we_cnt;
        set_req(0, 10'h004, 1'b0, WORD, 1'b0, 32'hFFFFFFFF);
        wait_accept(0, w);
        check("rd_ready_same_cycle", 32'(w), 32'd0);
        wait_rsp(0, d);
        check("rd_word", d, 32'h0DEFACED);
        check("rd_no_we", 32'(we_cnt - we0), 32'd0);

        // Byte write then read back
        we0 = we_cnt;
        set_req(1, 10'h003, 1'b1, BYTE, 1'b0, 32'h123456A7);
        wait_accept(1, w);
        wait_rsp(1, d);
        check("wr_rdata", d, 32'd0);
        check("wr_we_cycles", 32'(we_cnt - we0), 32'd1);
        check("wr_addr", 32'(we_addr), 32'h003);
        set_req(1, 10'h003, 1'b0, BYTE, 1'b0, 32'd0);
        wait_accept(1, w);
        wait_rsp(1, d);
        check("wr_readback", d, 32'h000000A7);

        // Backpressure on requester 0 while requester 1 waits
        we0 = we_cnt;
        bus.rsp_ready_i[0] = 1'b0;
        set_req(0, 10'h004, 1'b0, WORD, 1'b0, 32'd0);
        wait_accept(0, w);
        set_req(1, 10'h010, 1'b0, WORD, 1'b0, 32'd0);
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            if (bus.rsp_valid_o[0]) ok = 1;
        end
        check("bp_rise_timeout", 32'(ok), 32'd1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid_o), 32'b01);
            check("bp_rdata", bus.rsp_rdata_o, 32'h0DEFACED);
            check("bp_ready", 32'(bus.req_ready_o), 32'd0);
        end
        check("bp_no_we", 32'(we_cnt - we0), 32'd0);
        @(posedge clk);
        #1 bus.rsp_ready_i[0] = 1'b1;
        wait_accept(1, w);
        wait_rsp(1, d);
        check("bp_next", d, 32'h00000080);

        // Sign-extended byte read
        set_req(0, 10'h010, 1'b0, BYTE, 1'b1, 32'd0);
        wait_accept(0, w);
        check("sext_issue", 32'(bus.mem_sext_o), 32'd1);
        wait_rsp(0, d);
        check("sext_rdata", d, 32'hFFFFFF80);

        // Reset during ISSUE of a write
        set_req(0, 10'h020, 1'b1, WORD, 1'b0, 32'hCAFEBABE);
        wait_accept(0, w);
        check("rst_issue_we", 32'(bus.mem_we_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(bus.mem_we_o), 32'd0);
        check("rst_async_rsp", 32'(bus.rsp_valid_o), 32'd0);
        set_req(0, 10'h020, 1'b0, WORD, 1'b0, 32'd0);
        set_req(1, 10'h004, 1'b0, WORD, 1'b0, 32'd0);
        #1;
        check("rst_grant", 32'(bus.req_ready_o), 32'b01);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_accept(0, w);
        wait_rsp(0, d);
        check("rst_write_lost", d, 32'h11223344);
        wait_accept(1, w);
        wait_rsp(1, d);
        check("rst_after_req1", d, 32'h0DEFACED);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid_i[i] || acc_vec[i])
                    bus.req_valid_i[i] = ($urandom_range(0, 2) == 0);
                bus.req_addr_i[i]  = AW'($urandom_range(0, 31));
                bus.req_we_i[i]    = 1'($urandom);
                bus.req_width_i[i] = mem_width_t'($urandom_range(0, 2));
                bus.req_sext_i[i]  = 1'($urandom);
                bus.req_wdata_i[i] = $urandom;
            end
            bus.rsp_ready_i = NREQ'($urandom);
        end
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
